// File: rtl/reaction_ctrl_if.sv
// Reaction counter link: the trial controller drives enable/clear, the 16-bit
// counter returns its count and carry.
interface reaction_ctrl_if;
  logic        cnt_enable;
  logic        cnt_clear;
  logic [15:0] cnt_value;
  logic        cnt_carry;

  modport master (
    output cnt_enable,
    output cnt_clear,
    input  cnt_value,
    input  cnt_carry
  );

  modport slave (
    input  cnt_enable,
    input  cnt_clear,
    output cnt_value,
    output cnt_carry
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time trial controller: random pre-stimulus delay, ms metering through
// the external counter, capture on react, false-start and timeout detection.
module reaction_ctrl #(
  parameter int          TICK_DIV     = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter int          TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start_btn,
  input  logic            react_btn,
  reaction_ctrl_if.master cnt,
  output logic            led,
  output logic [15:0]     result,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout,
  output logic [2:0]      state
);

  localparam int             PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [16:0]    MIN_DELAY   = 17'(MIN_DELAY_MS);
  localparam logic [15:0]    TIMEOUT_VAL = 16'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t          state_r;
  logic [2:0]      start_sync_r;
  logic [2:0]      react_sync_r;
  logic            start_press_r;
  logic            react_press_r;
  logic [15:0]     lfsr_r;
  logic [PW-1:0]   presc_r;
  logic            tick_r;
  logic [16:0]     delay_r;
  logic            cnt_clear_r;
  logic [15:0]     result_r;
  logic            result_valid_r;
  logic            false_start_r;
  logic            timeout_r;
  logic            enter_arm_s;
  logic            enter_go_s;

  assign enter_arm_s = start_press_r &
                       ((state_r == IDLE) | (state_r == DONE) | (state_r == FAULT));
  assign enter_go_s  = (state_r == ARM) & ~react_press_r & tick_r & (delay_r <= 17'd1);

  assign cnt.cnt_enable = (state_r == GO) & tick_r;
  assign cnt.cnt_clear  = cnt_clear_r;
  assign led            = (state_r == GO);
  assign result         = result_r;
  assign result_valid   = result_valid_r;
  assign false_start    = false_start_r;
  assign timeout        = timeout_r;
  assign state          = state_r;

  // Button synchronisers and rising-edge press pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_sync_r  <= 3'b000;
      react_sync_r  <= 3'b000;
      start_press_r <= 1'b0;
      react_press_r <= 1'b0;
    end else begin
      start_sync_r  <= {start_sync_r[1:0], start_btn};
      react_sync_r  <= {react_sync_r[1:0], react_btn};
      start_press_r <= start_sync_r[1] & ~start_sync_r[2];
      react_press_r <= react_sync_r[1] & ~react_sync_r[2];
    end
  end

  // Free-running random source for the pre-stimulus delay
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // ms prescaler, realigned on ARM/GO entry so the first ms is never short
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else if (enter_arm_s | enter_go_s) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= '0;
      tick_r  <= 1'b1;
    end else begin
      presc_r <= presc_r + PW'(1);
      tick_r  <= 1'b0;
    end
  end

  // Trial FSM with registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r        <= IDLE;
      delay_r        <= 17'd0;
      cnt_clear_r    <= 1'b0;
      result_r       <= 16'd0;
      result_valid_r <= 1'b0;
      false_start_r  <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      cnt_clear_r <= 1'b0;
      case (state_r)
        IDLE, DONE, FAULT: begin
          if (start_press_r) begin
            state_r        <= ARM;
            cnt_clear_r    <= 1'b1;
            delay_r        <= MIN_DELAY + 17'(lfsr_r[RAND_BITS-1:0]);
            result_valid_r <= 1'b0;
            false_start_r  <= 1'b0;
            timeout_r      <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ARM: begin
          // A react landing on the expiry tick still counts as anticipation
          if (react_press_r) begin
            state_r       <= FAULT;
            false_start_r <= 1'b1;
          end else if (tick_r) begin
            if (delay_r <= 17'd1) begin
              state_r <= GO;
            end else begin
              delay_r <= delay_r - 17'd1;
            end
          end else begin
            state_r <= ARM;
          end
        end
        GO: begin
          if (react_press_r) begin
            state_r        <= DONE;
            result_r       <= cnt.cnt_value;
            result_valid_r <= 1'b1;
          end else if ((cnt.cnt_value == TIMEOUT_VAL) || cnt.cnt_carry) begin
            state_r   <= FAULT;
            timeout_r <= 1'b1;
          end else begin
            state_r <= GO;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomised directed bench for reaction_ctrl with a behavioural counter and
// LFSR reference; expected timings derived from the trial rules.
module tb_reaction_ctrl;

  localparam int          TICK_DIV     = 4;
  localparam int          MIN_DELAY_MS = 3;
  localparam int          RAND_BITS    = 2;
  localparam int          TIMEOUT_MS   = 20;
  localparam logic [15:0] SEED         = 16'hACE1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic        force_carry = 1'b0;
  logic        led;
  logic [15:0] result;
  logic        result_valid;
  logic        false_start;
  logic        timeout;
  logic [2:0]  state;

  logic [15:0] cval;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_prev;
  logic [15:0] last_result = 16'd0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          en_cnt = 0;
  int          en_stray = 0;
  bit          led_seen = 1'b0;

  reaction_ctrl_if cnt_bus();

  assign cnt_bus.cnt_value = cval;
  assign cnt_bus.cnt_carry = force_carry;

  reaction_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .MIN_DELAY_MS(MIN_DELAY_MS),
    .RAND_BITS   (RAND_BITS),
    .TIMEOUT_MS  (TIMEOUT_MS),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .cnt         (cnt_bus),
    .led         (led),
    .result      (result),
    .result_valid(result_valid),
    .false_start (false_start),
    .timeout     (timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Reaction counter: synchronous clear, increment on enable
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   cval <= 16'd0;
    else if (cnt_bus.cnt_clear)  cval <= 16'd0;
    else if (cnt_bus.cnt_enable) cval <= cval + 16'd1;
  end

  // Reference polynomial x^16+x^14+x^13+x^11+1; lfsr_prev is the value seen by the last edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_m    <= SEED;
      lfsr_prev <= SEED;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (led === 1'b1) led_seen = 1'b1;
    if (cnt_bus.cnt_enable === 1'b1) begin
      en_cnt++;
      if (led !== 1'b1) en_stray++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (state === s) break;
      step();
    end
    chk(tag, state, s);
  endtask

  // Press start, find the clear pulse and the delay the reference LFSR implies.
  // Returns one cycle after the clear cycle.
  task automatic do_start(output int d);
    bit found;
    found = 1'b0;
    d = 0;
    start_btn = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (cnt_bus.cnt_clear === 1'b1) begin
        found = 1'b1;
        d = MIN_DELAY_MS + int'(lfsr_prev[RAND_BITS-1:0]);
      end
    end
    chk("start_clear_seen", 32'(found), 32'd1);
    chk("arm_state", state, 32'd1);
    chk("arm_result_valid", result_valid, 32'd0);
    chk("arm_false_start", false_start, 32'd0);
    chk("arm_timeout", timeout, 32'd0);
    chk("arm_result_kept", result, last_result);
    start_btn = 1'b0;
    step();
    chk("clear_one_cycle", cnt_bus.cnt_clear, 32'd0);
  endtask

  task automatic wait_led(input int d);
    int n;
    n = 1;
    while (led !== 1'b1 && n < 4 * d + 12) begin
      step();
      n++;
    end
    chk("led_delay_in_window", 32'((n >= 4 * d) && (n <= 4 * d + 1)), 32'd1);
    en_cnt = 0;
  endtask

  task automatic run_trial(input int n, input bit race);
    int d;
    do_start(d);
    wait_led(d);
    for (int i = 0; i < 400 && en_cnt < n; i++) step();
    chk("pulses_reached", en_cnt, n);
    if (race) step();
    react_btn = 1'b1;
    wait_state(3'd3, 12, "done_state");
    chk("result", result, n);
    chk("result_valid", result_valid, 32'd1);
    chk("done_led_off", led, 32'd0);
    chk("done_false_start", false_start, 32'd0);
    chk("done_timeout", timeout, 32'd0);
    chk(race ? "race_post_increment" : "no_post_increment", cval, race ? n + 1 : n);
    react_btn = 1'b0;
    last_result = 16'(n);
  endtask

  initial begin
    int d;
    repeat (3) step();
    chk("reset_state_low", state, 32'd0);
    rstn = 1'b1;
    step();
    chk("reset_state", state, 32'd0);
    chk("reset_led", led, 32'd0);
    chk("reset_enable", cnt_bus.cnt_enable, 32'd0);
    chk("reset_clear", cnt_bus.cnt_clear, 32'd0);
    chk("reset_result_valid", result_valid, 32'd0);
    chk("reset_false_start", false_start, 32'd0);
    chk("reset_timeout", timeout, 32'd0);
    chk("reset_result", result, 32'd0);

    run_trial(10, 1'b0);

    // react presses in DONE must not disturb anything
    react_btn = 1'b1;
    repeat (8) step();
    react_btn = 1'b0;
    step();
    chk("done_ignores_react_state", state, 32'd3);
    chk("done_ignores_react_result", result, last_result);

    run_trial(7, 1'b1);

    for (int t = 0; t < 5; t++) begin
      repeat ($urandom_range(0, 7)) step();
      run_trial(int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    // false start two ticks into ARM
    led_seen = 1'b0;
    do_start(d);
    en_cnt = 0;
    repeat (7) step();
    react_btn = 1'b1;
    wait_state(3'd4, 12, "fs_state");
    react_btn = 1'b0;
    chk("fs_flag", false_start, 32'd1);
    chk("fs_timeout", timeout, 32'd0);
    chk("fs_led_never", 32'(led_seen), 32'd0);
    chk("fs_enable_never", en_cnt, 32'd0);
    chk("fs_result_kept", result, last_result);

    // react on the very tick that would end the delay
    led_seen = 1'b0;
    do_start(d);
    repeat (4 * d - 4) step();
    react_btn = 1'b1;
    wait_state(3'd4, 12, "arm_race_state");
    react_btn = 1'b0;
    chk("arm_race_false_start", false_start, 32'd1);
    chk("arm_race_led_never", 32'(led_seen), 32'd0);

    // timeout at TIMEOUT_MS
    do_start(d);
    wait_led(d);
    wait_state(3'd4, 200, "timeout_state");
    chk("timeout_flag", timeout, 32'd1);
    chk("timeout_count", cval, TIMEOUT_MS);
    chk("timeout_pulses", en_cnt, TIMEOUT_MS);
    chk("timeout_false_start", false_start, 32'd0);
    chk("timeout_result_valid", result_valid, 32'd0);

    // timeout forced by counter carry
    do_start(d);
    wait_led(d);
    for (int i = 0; i < 100 && cval != 16'd5; i++) step();
    force_carry = 1'b1;
    wait_state(3'd4, 8, "carry_state");
    force_carry = 1'b0;
    chk("carry_timeout", timeout, 32'd1);
    chk("carry_count", cval, 32'd5);

    run_trial(int'($urandom_range(1, 15)), 1'b0);

    // asynchronous reset in the middle of GO
    do_start(d);
    wait_led(d);
    repeat (3) step();
    rstn = 1'b0;
    #1;
    chk("rst_go_led", led, 32'd0);
    chk("rst_go_state", state, 32'd0);
    chk("rst_go_result", result, 32'd0);
    chk("rst_go_result_valid", result_valid, 32'd0);
    chk("rst_go_enable", cnt_bus.cnt_enable, 32'd0);
    last_result = 16'd0;
    step();
    rstn = 1'b1;
    repeat (2) step();
    chk("after_reset_state", state, 32'd0);

    chk("no_enable_outside_go", en_stray, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
